// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation sequencer and its slot counter.
package movegen_pkg;

    localparam int MOVE_W      = 32;
    localparam int NUM_SQUARES = 64;
    localparam int NUM_DIRS    = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        PROP,
        SCAN,
        EMIT,
        DONE
    } state_t;

    // Direction slot numbering used by the square array's move-word outputs
    localparam logic [3:0] U   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] L   = 4'd2;
    localparam logic [3:0] R   = 4'd3;
    localparam logic [3:0] UL  = 4'd4;
    localparam logic [3:0] UR  = 4'd5;
    localparam logic [3:0] DL  = 4'd6;
    localparam logic [3:0] DR  = 4'd7;
    localparam logic [3:0] UUL = 4'd8;
    localparam logic [3:0] UUR = 4'd9;
    localparam logic [3:0] LLU = 4'd10;
    localparam logic [3:0] RRU = 4'd11;
    localparam logic [3:0] DDL = 4'd12;
    localparam logic [3:0] DDR = 4'd13;
    localparam logic [3:0] LLD = 4'd14;
    localparam logic [3:0] RRD = 4'd15;

endpackage

// File: rtl/movegen_slot_counter.sv
// Nested square/direction index: direction is the inner loop, square the outer.
// Saturates on the last slot so the index never wraps within a pass.
module movegen_slot_counter #(
    parameter int NUM_SQUARES = movegen_pkg::NUM_SQUARES,
    parameter int NUM_DIRS    = movegen_pkg::NUM_DIRS,
    parameter int SQ_W        = $clog2(NUM_SQUARES),
    parameter int DIR_W       = $clog2(NUM_DIRS)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    output logic [SQ_W-1:0]  sel_square,
    output logic [DIR_W-1:0] sel_dir,
    output logic             last
);

    logic dir_last;

    assign dir_last = (sel_dir == DIR_W'(NUM_DIRS - 1));
    assign last     = dir_last && (sel_square == SQ_W'(NUM_SQUARES - 1));

    always_ff @(posedge clk) begin
        if (clear || load) begin
            sel_square <= '0;
            sel_dir    <= '0;
        end else if (advance && !last) begin
            if (dir_last) begin
                sel_dir    <= '0;
                sel_square <= sel_square + 1'b1;
            end else begin
                sel_dir <= sel_dir + 1'b1;
            end
        end
    end

endmodule

// File: rtl/movegen_sequencer.sv
// Runs one move-generation pass: clear the square array, let sliding rays propagate,
// then scan every square/direction slot and stream out the non-zero move words.
module movegen_sequencer #(
    parameter int NUM_SQUARES = movegen_pkg::NUM_SQUARES,
    parameter int NUM_DIRS    = movegen_pkg::NUM_DIRS,
    parameter int PROP_CYCLES = 8,
    parameter int MOVE_W      = movegen_pkg::MOVE_W
) (
    input  logic                                        clk,
    input  logic                                        clear,
    input  logic                                        start,
    input  logic                                        engine_color,
    output logic                                        sq_clear,
    output logic                                        sq_enable,
    output logic                                        sq_engine_color,
    output logic [$clog2(NUM_SQUARES)-1:0]              sel_square,
    output logic [$clog2(NUM_DIRS)-1:0]                 sel_dir,
    input  logic [MOVE_W-1:0]                           move_word_in,
    output logic [MOVE_W-1:0]                           move_out,
    output logic                                        move_valid,
    input  logic                                        move_ready,
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(NUM_SQUARES*NUM_DIRS+1)-1:0]   move_count
);

    import movegen_pkg::*;

    localparam int PROP_W = $clog2(PROP_CYCLES + 1);

    state_t            state, state_nxt;
    logic [PROP_W-1:0] prop_cnt;
    logic              accept_start;
    logic              advance;
    logic              capture;
    logic              handshake;
    logic              last;

    movegen_slot_counter #(
        .NUM_SQUARES(NUM_SQUARES),
        .NUM_DIRS   (NUM_DIRS)
    ) u_slot (
        .clk       (clk),
        .clear     (clear),
        .load      (accept_start),
        .advance   (advance),
        .sel_square(sel_square),
        .sel_dir   (sel_dir),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        advance      = 1'b0;
        capture      = 1'b0;
        handshake    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept_start = 1'b1;
                state_nxt    = CLR;
            end
            CLR:  state_nxt = PROP;
            PROP: if (prop_cnt == '0) state_nxt = SCAN;
            SCAN: begin
                // Index stays put on a hit so sel_* names the emitted slot during EMIT
                if (move_word_in != '0) begin
                    capture   = 1'b1;
                    state_nxt = EMIT;
                end else if (last) begin
                    state_nxt = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            EMIT: if (move_ready) begin
                handshake = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sq_engine_color <= 1'b0;
            move_count      <= '0;
            move_out        <= '0;
            prop_cnt        <= '0;
        end else begin
            if (accept_start) begin
                sq_engine_color <= engine_color;
                move_count      <= '0;
            end
            if (handshake) move_count <= move_count + 1'b1;
            if (capture)   move_out   <= move_word_in;
            if (state == CLR)
                prop_cnt <= PROP_W'(PROP_CYCLES - 1);
            else if (state == PROP && prop_cnt != '0)
                prop_cnt <= prop_cnt - 1'b1;
        end
    end

    assign sq_clear   = (state == CLR);
    assign sq_enable  = (state == PROP);
    assign move_valid = (state == EMIT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed bench for movegen_sequencer: a board model feeds the move-word mux and a
// scoreboard queue holds the moves each pass is expected to stream out.
module tb_movegen_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        engine_color;
    logic        sq_clear;
    logic        sq_enable;
    logic        sq_engine_color;
    logic [5:0]  sel_square;
    logic [3:0]  sel_dir;
    logic [31:0] move_word_in;
    logic [31:0] move_out;
    logic        move_valid;
    logic        move_ready;
    logic        busy;
    logic        done;
    logic [10:0] move_count;

    logic [31:0] board [0:1023];
    logic [41:0] expq [$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign move_word_in = board[{sel_square, sel_dir}];

    movegen_sequencer dut (
        .clk            (clk),
        .clear          (clear),
        .start          (start),
        .engine_color   (engine_color),
        .sq_clear       (sq_clear),
        .sq_enable      (sq_enable),
        .sq_engine_color(sq_engine_color),
        .sel_square     (sel_square),
        .sel_dir        (sel_dir),
        .move_word_in   (move_word_in),
        .move_out       (move_out),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .busy           (busy),
        .done           (done),
        .move_count     (move_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 1024; i++) board[i] = 32'h0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_valid"},      move_valid, 0);
        check({tag, "_sq_clear"},   sq_clear, 0);
        check({tag, "_sq_enable"},  sq_enable, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_color"},      sq_engine_color, 0);
        check({tag, "_move_out"},   move_out, 0);
        check({tag, "_move_count"}, move_count, 0);
        check({tag, "_sel"},        {sel_square, sel_dir}, 0);
    endtask

    task automatic run_pass(input string tag, input logic color, input bit inject,
                            input int stall, input int exp_moves, input int exp_busy);
        int nclr = 0, nen = 0, nbusy = 0, nstall = 0, beats = 0;
        bit seen_done = 0, col_bad = 0, stall_bad = 0;
        logic [31:0] held = '0;
        logic [41:0] e;
        expq.delete();
        for (int i = 0; i < 1024; i++)
            if (board[i] != 32'h0) expq.push_back({10'(i), board[i]});
        move_ready = (stall == 0);
        @(posedge clk); #1;
        engine_color = color;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000 && !seen_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (sq_clear) nclr++;
            if (sq_enable) nen++;
            if (sq_engine_color !== color) col_bad = 1;
            if (inject && sq_enable && nen == 3) begin
                start = 1'b1;
                engine_color = ~color;
            end
            if (move_valid && !move_ready) begin
                if (nstall == 0) held = move_out;
                else if (move_out !== held || sel_square !== 6'd0 || sel_dir !== 4'd0) stall_bad = 1;
                nstall++;
                if (nstall >= stall) move_ready = 1'b1;
            end
            if (move_valid && move_ready) begin
                beats++;
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check({tag, "_beat_word"}, move_out, e[31:0]);
                    check({tag, "_beat_slot"}, {sel_square, sel_dir}, e[41:32]);
                end
            end
            if (done) begin
                seen_done = 1;
                start = 1'b1;
            end
        end
        check({tag, "_done_seen"},   seen_done, 1);
        check({tag, "_clr_cycles"},  nclr, 1);
        check({tag, "_en_cycles"},   nen, 8);
        check({tag, "_busy_cycles"}, nbusy, exp_busy);
        check({tag, "_move_count"},  move_count, exp_moves);
        check({tag, "_beats"},       beats, exp_moves);
        check({tag, "_queue_left"},  expq.size(), 0);
        check({tag, "_color_held"},  col_bad, 0);
        if (stall > 0) begin
            check({tag, "_stall_cycles"}, nstall, stall);
            check({tag, "_stall_stable"}, stall_bad, 0);
        end
        @(negedge clk);
        check({tag, "_start_at_done_ignored"}, busy, 0);
        start = 1'b0;
        move_ready = 1'b1;
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b1;
        engine_color = 1'b1;
        move_ready = 1'b1;
        clear_board();

        // Reset, with start asserted alongside clear
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        @(negedge clk);
        check("reset_start_ignored", busy, 0);

        // Empty board
        run_pass("empty", 1'b0, 0, 0, 0, 1034);

        // Two moves, including the very last slot
        board[27*16 + 2] = 32'h0000_1B1A;
        board[63*16 + 15] = 32'h8000_003F;
        run_pass("two", 1'b0, 0, 0, 2, 1036);
        clear_board();

        // Backpressure on the first slot
        board[0] = 32'h1;
        run_pass("bp", 1'b0, 0, 20, 1, 1054);
        clear_board();

        // Abort with a move pending
        board[5*16 + 3] = 32'h0000_0055;
        move_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 2000 && !move_valid; c++) @(negedge clk);
        check("abort_reached_emit", move_valid, 1);
        check("abort_emit_word", move_out, 32'h55);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle_zero("abort");
        move_ready = 1'b1;
        run_pass("after_abort", 1'b0, 0, 0, 1, 1035);
        clear_board();

        // Colour latch and start while busy
        run_pass("color", 1'b1, 1, 0, 0, 1034);
        check("color_final", sq_engine_color, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
